wilton_cfg_loader: RTL
======================

Name: wilton_cfg_loader

Overview:
Configuration controller for an array of Wilton switch boxes.
- Accepts a byte stream over a valid/ready handshake.
- Assembles each switch's 4 x 8-bit configuration word in shadow registers.
- Commits all switches atomically in one cycle, so no switch box ever sees a partially written configuration.
- Sits between the bitstream source (host/SPI front end) and the `configuration_word` inputs of the switch-box fabric.

Parameters:
- NUM_SWITCHES, 4, number of switch boxes driven; legal range 1..64.
- BYTES_PER_SWITCH, 4 (localparam, from package), bytes per switch configuration word; one byte per track index, 2-bit select per side.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel a load in progress; sampled in LOAD/CHECK.
- cfg_valid  in  1  byte-stream valid.
- cfg_data  in  8  byte-stream data.
- cfg_ready  out  1  loader accepts a byte this cycle.
- sw_conf  out  NUM_SWITCHES*32  active configuration; switch s byte b is at bits [(s*4+b)*8 +: 8].
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on commit.
- err  out  1  one-cycle pulse on a failed load.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; counters = 0.
  - shadow = 0, sw_conf = 0 (all selects 0 = every pin undriven/disconnected).
  - cfg_ready = 0, busy = 0, done = 0, err = 0.
  - Reset mid-load discards the load; sw_conf returns to 0.
- IDLE: cfg_ready = 0. start = 1 -> LOAD next cycle; byte_idx = 0, sw_idx = 0, shadow cleared.
- LOAD: cfg_ready = 1 combinationally from state.
  - Transfer happens when cfg_valid && cfg_ready.
  - Each transfer writes shadow[sw_idx][byte_idx] = cfg_data.
  - byte_idx increments and wraps 3 -> 0; sw_idx increments on that wrap.
  - Byte order: switch 0 byte 0 first, switch NUM_SWITCHES-1 byte 3 last.
  - Transfer of the last byte (sw_idx = NUM_SWITCHES-1, byte_idx = 3) -> COMMIT, or -> CHECK when the parity feature is enabled.
  - cfg_valid low stalls indefinitely; no timeout.
  - start is ignored in LOAD.
- COMMIT (1 cycle): cfg_ready = 0; sw_conf <= shadow; done = 1 for this single cycle; -> IDLE.
  - Latency: sw_conf updates on the clock edge one cycle after the last byte handshake.
- abort in LOAD/CHECK: -> IDLE next cycle; shadow discarded; sw_conf unchanged; err pulses 1 cycle.
  - abort coincident with the last-byte handshake: abort wins; the handshake is consumed, no commit.
- sw_conf changes only in COMMIT or on reset.
- Total bytes per load: NUM_SWITCHES*4, plus 1 when the parity feature is enabled.

Optional Feature:
- Macro: WILTON_CFG_PARITY_EN.
- Defined:
  - LOAD is followed by CHECK (cfg_ready = 1), which accepts one extra byte.
  - Commit requires that byte to equal the XOR of all payload bytes. Match -> COMMIT. Mismatch -> IDLE with an err pulse; sw_conf unchanged.
- Undefined: CHECK state absent; err asserts only on abort.

Decomposition:
- Package wilton_cfg_pkg contains:
  - state enum: IDLE, LOAD, CHECK, COMMIT.
  - BYTES_PER_SWITCH = 4, SEL_W = 2, CFG_BYTE_W = 8.
  - Helper function computing sw_conf bit offset from (switch, byte).
- One sub-module is natural: wilton_cfg_shadow, the shadow register file with write-enable and clear, flat-bus output.
- The FSM and counters stay in the top module.

Test Plan:
- Reset then idle: hold reset 2 cycles -> sw_conf = 0, cfg_ready = 0, busy = 0; cfg_valid = 1 with no start -> no byte accepted.
- Full load, NUM_SWITCHES = 4, bytes 0x00..0x0F continuously valid -> cfg_ready high 16 cycles. Then done pulses once; sw_conf[7:0] = 0x00 and sw_conf[127:120] = 0x0F. busy falls the cycle after done.
- Back-pressure: cfg_valid toggled every other cycle with the same 16 bytes -> identical sw_conf. sw_conf stays at its prior value until the commit edge.
- Abort after byte 7 with prior sw_conf = all 0xA5 -> err pulse, sw_conf remains 0xA5 everywhere. A following load of 16 x 0x3C -> sw_conf = all 0x3C.
- Abort coincident with byte 15 -> no done, err = 1, sw_conf unchanged.
- WILTON_CFG_PARITY_EN defined:
  - bytes 0x01..0x10 plus parity 0x10 -> done, commit.
  - same bytes plus parity 0x11 -> err, sw_conf unchanged.

Source files
------------

// File: rtl/wilton_cfg_pkg.sv
// wilton_cfg_pkg: shared types and constants for the Wilton switch-box
// configuration loader.
//   state_e          loader FSM states (CHECK only reached with parity enabled)
//   BYTES_PER_SWITCH bytes per switch configuration word
//   SEL_W            select width per side within a configuration byte
//   CFG_BYTE_W       width of one stream byte
//   conf_off()       bit offset of (switch, byte) in the flat sw_conf bus
package wilton_cfg_pkg;
  localparam int BYTES_PER_SWITCH = 4;
  localparam int BYTE_IDX_W       = $clog2(BYTES_PER_SWITCH);
  localparam int SEL_W            = 2;
  localparam int CFG_BYTE_W       = 8;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_e;

  function automatic int conf_off(input int sw, input int b);
    return (sw * BYTES_PER_SWITCH + b) * CFG_BYTE_W;
  endfunction
endpackage

// File: rtl/wilton_cfg_shadow.sv
// wilton_cfg_shadow: shadow register file holding the configuration being
// assembled. One row per switch, one byte written per enabled cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears all rows)
//   clr          synchronous clear of all rows (start of a new load)
//   we           write wdata into row sw_idx, byte byte_idx
//   shadow       flat bus, same layout as sw_conf
module wilton_cfg_shadow
  import wilton_cfg_pkg::*;
#(
  parameter int NUM_SWITCHES = 4,
  parameter int SW_W         = 2
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              clr,
  input  logic                                              we,
  input  logic [SW_W-1:0]                                   sw_idx,
  input  logic [BYTE_IDX_W-1:0]                             byte_idx,
  input  logic [CFG_BYTE_W-1:0]                             wdata,
  output logic [NUM_SWITCHES*BYTES_PER_SWITCH*CFG_BYTE_W-1:0] shadow
);
  for (genvar s = 0; s < NUM_SWITCHES; s++) begin : g_row
    logic [BYTES_PER_SWITCH-1:0][CFG_BYTE_W-1:0] row_q;

    always_ff @(posedge clk) begin
      if (reset || clr)
        row_q <= '0;
      else if (we && sw_idx == SW_W'(s))
        row_q[byte_idx] <= wdata;
    end

    for (genvar b = 0; b < BYTES_PER_SWITCH; b++) begin : g_byte
      assign shadow[conf_off(s, b) +: CFG_BYTE_W] = row_q[b];
    end
  end
endmodule

// File: rtl/wilton_cfg_loader.sv
// wilton_cfg_loader: byte-stream configuration loader for an array of Wilton
// switch boxes. Bytes are assembled in a shadow file and committed to sw_conf
// in a single cycle so the fabric never sees a partial configuration.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start                begin a load (IDLE only)
//   abort                cancel a load (LOAD/CHECK), pulses err
//   cfg_valid/cfg_data   byte stream in, cfg_ready is the accept
//   sw_conf              active configuration, switch s byte b at (s*4+b)*8
//   busy                 loader not idle
//   done / err           one-cycle commit / failed-load pulses
// Build option: define WILTON_CFG_PARITY_EN to require a trailing XOR parity
// byte (CHECK state) before commit.
module wilton_cfg_loader
  import wilton_cfg_pkg::*;
#(
  parameter int NUM_SWITCHES = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              abort,
  input  logic                                              cfg_valid,
  input  logic [CFG_BYTE_W-1:0]                             cfg_data,
  output logic                                              cfg_ready,
  output logic [NUM_SWITCHES*BYTES_PER_SWITCH*CFG_BYTE_W-1:0] sw_conf,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              err
);
  localparam int SW_W   = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;
  localparam int CONF_W = NUM_SWITCHES * BYTES_PER_SWITCH * CFG_BYTE_W;

  state_e                  state_q, state_d;
  logic [SW_W-1:0]         sw_idx_q;
  logic [BYTE_IDX_W-1:0]   byte_idx_q;
  logic [CONF_W-1:0]       shadow;
  logic                    xfer, last_byte, shadow_clr, shadow_we, err_d;

  assign cfg_ready  = (state_q == LOAD) || (state_q == CHECK);
  assign xfer       = cfg_valid && cfg_ready;
  assign last_byte  = (sw_idx_q == SW_W'(NUM_SWITCHES - 1)) &&
                      (byte_idx_q == BYTE_IDX_W'(BYTES_PER_SWITCH - 1));
  assign shadow_clr = (state_q == IDLE) && start;
  // Writes during an aborted last-byte cycle are harmless: the shadow is
  // cleared before it can be committed again.
  assign shadow_we  = xfer && (state_q == LOAD);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == COMMIT);

`ifdef WILTON_CFG_PARITY_EN
  logic [CFG_BYTE_W-1:0] par_q;

  always_ff @(posedge clk) begin
    if (reset || shadow_clr) par_q <= '0;
    else if (shadow_we)      par_q <= par_q ^ cfg_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (xfer && last_byte) begin
`ifdef WILTON_CFG_PARITY_EN
          state_d = CHECK;
`else
          state_d = COMMIT;
`endif
        end
      end
`ifdef WILTON_CFG_PARITY_EN
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (xfer) begin
          if (cfg_data == par_q) begin
            state_d = COMMIT;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      err     <= 1'b0;
      sw_conf <= '0;
    end else begin
      state_q <= state_d;
      err     <= err_d;
      if (state_q == COMMIT) sw_conf <= shadow;
    end
  end

  // byte_idx wraps naturally at BYTES_PER_SWITCH (power of two).
  always_ff @(posedge clk) begin
    if (reset || shadow_clr) begin
      sw_idx_q   <= '0;
      byte_idx_q <= '0;
    end else if (shadow_we) begin
      byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
      if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_SWITCH - 1))
        sw_idx_q <= sw_idx_q + SW_W'(1);
    end
  end

  wilton_cfg_shadow #(
    .NUM_SWITCHES(NUM_SWITCHES),
    .SW_W        (SW_W)
  ) u_shadow (
    .clk     (clk),
    .reset   (reset),
    .clr     (shadow_clr),
    .we      (shadow_we),
    .sw_idx  (sw_idx_q),
    .byte_idx(byte_idx_q),
    .wdata   (cfg_data),
    .shadow  (shadow)
  );
endmodule
